// File: rtl/sigmoid_pipe_if.sv
// Valid/ready stream bundle around sigmoid_pipe: sample channel in, activation channel out.
interface sigmoid_pipe_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sigmoid_pipe.sv
// Three-stage activation unit: decode |x| and region, evaluate u with shifts/adds, then scale,
// mirror for negative sigmoid inputs and saturate to Q0.OUT_W.
module sigmoid_pipe #(
  parameter int IN_W    = 8,
  parameter int IN_FRAC = 4,
  parameter int OUT_W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sigmoid_pipe_if.slave bus
);
  localparam int AW = IN_W + 1;     // magnitude width, holds |-2^(IN_W-1)|
  localparam int F  = IN_FRAC + 5;  // fractional bits of u
  localparam int UW = F + 1;        // u spans [0, 1.0]
  localparam int EW = IN_W + 6;     // headroom for shifted magnitudes and constants
  localparam int QW = OUT_W + 1;

  localparam logic [EW-1:0] A_ONE  = EW'(1) << IN_FRAC;
  localparam logic [EW-1:0] A_FIVE = EW'(5) << IN_FRAC;
  localparam logic [EW-1:0] A8_R2  = EW'(19) << IN_FRAC;  // 2.375 compared against 8*a
  localparam logic [EW-1:0] U_ONE  = EW'(1) << F;
  localparam logic [EW-1:0] U_HALF = EW'(1) << (F - 1);
  localparam logic [EW-1:0] U_R1   = EW'(5) << (F - 3);   // 0.625
  localparam logic [EW-1:0] U_R2   = EW'(27) << IN_FRAC;  // 0.84375 = 27/32
  localparam logic [QW-1:0] Q_FULL = QW'(1) << OUT_W;

  typedef enum logic [1:0] {REG0, REG1, REG2, REG3} region_t;
  typedef enum logic [1:0] {K_SIG, K_HARD, K_RELU} kind_t;

  logic en;

  logic          s1_valid_reg;
  logic          s1_sign_reg;
  logic [AW-1:0] s1_mag_reg;
  region_t       s1_region_reg;
  kind_t         s1_kind_reg;
  logic          s1_last_reg;

  logic          s2_valid_reg;
  logic [UW-1:0] s2_u_reg;
  logic          s2_flip_reg;
  logic          s2_last_reg;

  logic             out_valid_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic             out_last_reg;

  assign en           = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;

  // S1 decode
  logic [AW-1:0] x_ext;
  logic [AW-1:0] mag_next;
  logic [EW-1:0] mag_wide;
  region_t       region_next;
  kind_t         kind_next;

  always_comb begin
    x_ext    = {bus.in_data[IN_W-1], bus.in_data};
    mag_next = x_ext[AW-1] ? (~x_ext + AW'(1)) : x_ext;
    mag_wide = EW'(mag_next);
    if (mag_wide >= A_FIVE) begin
      region_next = REG3;
    end else if ((mag_wide << 3) >= A8_R2) begin
      region_next = REG2;
    end else if (mag_wide >= A_ONE) begin
      region_next = REG1;
    end else begin
      region_next = REG0;
    end
    case (bus.in_mode)
      2'd1:    kind_next = K_HARD;
      2'd2:    kind_next = K_RELU;
      default: kind_next = K_SIG;  // mode 3 runs as sigmoid
    endcase
  end

  // S2 evaluate
  logic [EW-1:0]      mag2;
  logic [EW-1:0]      sig_u;
  logic [EW-1:0]      hard_u;
  logic [EW-1:0]      relu_u;
  logic [EW-1:0]      u_sel;
  logic signed [EW:0] x_signed;
  logic signed [EW:0] hard_raw;

  always_comb begin
    mag2 = EW'(s1_mag_reg);
    case (s1_region_reg)
      REG0:    sig_u = (mag2 << 3) + U_HALF;
      REG1:    sig_u = (mag2 << 2) + U_R1;
      REG2:    sig_u = mag2 + U_R2;
      default: sig_u = U_ONE;
    endcase

    // Hard-sigmoid works on the signed input, not on the mirrored magnitude.
    x_signed = s1_sign_reg ? -$signed({1'b0, mag2}) : $signed({1'b0, mag2});
    hard_raw = (x_signed <<< 3) + $signed({1'b0, U_HALF});
    if (hard_raw[EW]) begin
      hard_u = '0;
    end else if (hard_raw > $signed({1'b0, U_ONE})) begin
      hard_u = U_ONE;
    end else begin
      hard_u = hard_raw[EW-1:0];
    end

    if (s1_sign_reg) begin
      relu_u = '0;
    end else if ((mag2 << 5) > U_ONE) begin
      relu_u = U_ONE;
    end else begin
      relu_u = mag2 << 5;
    end

    case (s1_kind_reg)
      K_HARD:  u_sel = hard_u;
      K_RELU:  u_sel = relu_u;
      default: u_sel = sig_u;
    endcase
  end

  // S3 finalise
  logic [QW-1:0]    q;
  logic [QW-1:0]    q_flip;
  logic [OUT_W-1:0] y_next;

  always_comb begin
    q      = QW'({s2_u_reg, {OUT_W{1'b0}}} >> F);
    q_flip = s2_flip_reg ? (Q_FULL - q) : q;
    y_next = q_flip[OUT_W] ? {OUT_W{1'b1}} : q_flip[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (en) begin
      s1_valid_reg  <= bus.in_valid;
      s2_valid_reg  <= s1_valid_reg;
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_data_reg <= y_next;
        out_last_reg <= s2_last_reg;
      end
    end
  end

  // Payload registers only move with a valid sample, so bubbles leave them untouched.
  always_ff @(posedge clk) begin
    if (en && bus.in_valid) begin
      s1_sign_reg   <= bus.in_data[IN_W-1];
      s1_mag_reg    <= mag_next;
      s1_region_reg <= region_next;
      s1_kind_reg   <= kind_next;
      s1_last_reg   <= bus.in_last;
    end
    if (en && s1_valid_reg) begin
      s2_u_reg    <= UW'(u_sel);
      s2_flip_reg <= s1_sign_reg && (s1_kind_reg == K_SIG);
      s2_last_reg <= s1_last_reg;
    end
  end
endmodule

// File: tb/tb_sigmoid_pipe.sv
// Bench for sigmoid_pipe: default and (12,8,10) instances, scoreboard of expected activations.
module tb_sigmoid_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sigmoid_pipe_if #(.IN_W(8),  .OUT_W(8))  bus_a ();
  sigmoid_pipe_if #(.IN_W(12), .OUT_W(10)) bus_b ();

  sigmoid_pipe #(.IN_W(8),  .IN_FRAC(4), .OUT_W(8))  dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  sigmoid_pipe #(.IN_W(12), .IN_FRAC(8), .OUT_W(10)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int exp_q[$];
  bit last_q[$];
  int cyc_q[$];

  bit obs_took, obs_got, obs_valid, obs_ready, obs_last;
  int obs_data, obs_cycle;

  // Real-valued reference of the activation definitions.
  function automatic int model(int d, int m, int in_w, int in_frac, int out_w);
    int xi, q, full;
    real x, a, u;
    xi = d & ((1 << in_w) - 1);
    if (xi >= (1 << (in_w - 1))) xi = xi - (1 << in_w);
    x = real'(xi) / real'(1 << in_frac);
    a = (x < 0.0) ? -x : x;
    if (m == 3) m = 0;
    if (m == 0) begin
      if (a >= 5.0)        u = 1.0;
      else if (a >= 2.375) u = a / 32.0 + 0.84375;
      else if (a >= 1.0)   u = a / 8.0 + 0.625;
      else                 u = a / 4.0 + 0.5;
    end else if (m == 1) begin
      u = x / 4.0 + 0.5;
      if (u < 0.0) u = 0.0;
      if (u > 1.0) u = 1.0;
    end else begin
      u = (x < 0.0) ? 0.0 : ((a > 1.0) ? 1.0 : a);
    end
    full = 1 << out_w;
    q = $rtoi(u * real'(full));
    if (m == 0 && x < 0.0) q = full - q;
    if (q >= full) q = full - 1;
    return q;
  endfunction

  // One clock of stimulus on the chosen instance; observations land in obs_*.
  task automatic step(input int which, input bit v, input int d, input int m, input bit l, input bit ordy);
    @(negedge clk);
    obs_cycle = cycle;
    if (which == 0) begin
      obs_valid = bus_a.out_valid; obs_data = int'(bus_a.out_data); obs_last = bus_a.out_last;
      bus_a.in_valid = v; bus_a.in_data = 8'(d); bus_a.in_mode = 2'(m);
      bus_a.in_last = l; bus_a.out_ready = ordy;
      #1 obs_ready = bus_a.in_ready;
    end else begin
      obs_valid = bus_b.out_valid; obs_data = int'(bus_b.out_data); obs_last = bus_b.out_last;
      bus_b.in_valid = v; bus_b.in_data = 12'(d); bus_b.in_mode = 2'(m);
      bus_b.in_last = l; bus_b.out_ready = ordy;
      #1 obs_ready = bus_b.in_ready;
    end
    obs_got  = obs_valid && ordy;
    obs_took = v && obs_ready;
  endtask

  task automatic push(input int e, input bit l);
    exp_q.push_back(e);
    last_q.push_back(l);
    cyc_q.push_back(obs_cycle);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks += 8;
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", bus_a.out_valid); end
    if (bus_a.out_data !== 8'd0)  begin errors++; $display("FAIL reset_a_data: got %0d expected 0", bus_a.out_data); end
    if (bus_a.out_last !== 1'b0)  begin errors++; $display("FAIL reset_a_last: got %b expected 0", bus_a.out_last); end
    if (bus_a.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_a_ready: got %b expected 1", bus_a.in_ready); end
    if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b expected 0", bus_b.out_valid); end
    if (bus_b.out_data !== 10'd0) begin errors++; $display("FAIL reset_b_data: got %0d expected 0", bus_b.out_data); end
    if (bus_b.out_last !== 1'b0)  begin errors++; $display("FAIL reset_b_last: got %b expected 0", bus_b.out_last); end
    if (bus_b.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_b_ready: got %b expected 1", bus_b.in_ready); end
    $display("reset: outputs cleared");
  endtask

  task automatic test_sigmoid();
    int xs[8] = '{8'h00, 8'h10, 8'hF0, 8'h20, 8'h30, 8'hD0, 8'h50, 8'h80};
    int ys[8] = '{128, 192, 64, 224, 240, 16, 255, 0};
    int idx = 0, outs = 0, first_cyc = -1, last_cyc = -1, e, ec;
    for (int t = 0; t < 40 && (idx < 8 || exp_q.size() > 0); t++) begin
      step(0, idx < 8, (idx < 8) ? xs[idx] : 0, 0, 1'b0, 1'b1);
      if (obs_took) begin push(ys[idx], 1'b0); idx++; end
      if (obs_got) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sigmoid_extra: unexpected output %0d", obs_data);
        end else begin
          e = exp_q.pop_front(); void'(last_q.pop_front()); ec = cyc_q.pop_front();
          checks++;
          if (obs_data !== e) begin errors++; $display("FAIL sigmoid_data[%0d]: got %0d expected %0d", outs, obs_data, e); end
          if (obs_cycle - ec !== 3) begin errors++; $display("FAIL sigmoid_latency[%0d]: got %0d expected 3", outs, obs_cycle - ec); end
          $display("sigmoid[%0d]: y=%0d expected %0d", outs, obs_data, e);
        end
        if (first_cyc < 0) first_cyc = obs_cycle;
        last_cyc = obs_cycle;
        outs++;
      end
    end
    checks += 2;
    if (outs !== 8) begin errors++; $display("FAIL sigmoid_count: got %0d expected 8", outs); end
    if (last_cyc - first_cyc !== 7) begin errors++; $display("FAIL sigmoid_contiguous: span %0d expected 7", last_cyc - first_cyc); end
  endtask

  task automatic test_modes();
    int xs[13] = '{8'h00, 8'h10, 8'hE0, 8'h20, 8'h08, 8'hF8, 8'h30, 8'h00, 8'h10, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    int ms[13] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 0, 1, 2, 3};
    int ys[13] = '{128, 192, 0, 255, 128, 0, 255, 0, 192, 255, 255, 255, 255};
    int idx = 0, outs = 0, e;
    for (int t = 0; t < 60 && (idx < 13 || exp_q.size() > 0); t++) begin
      step(0, idx < 13, (idx < 13) ? xs[idx] : 0, (idx < 13) ? ms[idx] : 0, 1'b0, 1'b1);
      if (obs_took) begin push(ys[idx], 1'b0); idx++; end
      if (obs_got) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL modes_extra: unexpected output %0d", obs_data);
        end else begin
          e = exp_q.pop_front(); void'(last_q.pop_front()); void'(cyc_q.pop_front());
          if (obs_data !== e) begin errors++; $display("FAIL modes_data[%0d]: got %0d expected %0d", outs, obs_data, e); end
          $display("modes[%0d]: y=%0d expected %0d", outs, obs_data, e);
        end
        outs++;
      end
    end
    checks++;
    if (outs !== 13) begin errors++; $display("FAIL modes_count: got %0d expected 13", outs); end
  endtask

  task automatic test_backpressure();
    int xs[6] = '{8'h05, 8'hE8, 8'h27, 8'h90, 8'h44, 8'hFC};
    int idx = 0, outs = 0, stalls = 0, e;
    bit ordy;
    for (int t = 0; t < 60 && (idx < 6 || exp_q.size() > 0); t++) begin
      ordy = !(t >= 4 && t < 8);
      step(0, idx < 6, (idx < 6) ? xs[idx] : 0, idx % 3, 1'b0, ordy);
      if (obs_valid && !ordy) begin
        checks++; stalls++;
        if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0 at t=%0d", obs_ready, t); end
      end
      if (obs_took) begin push(model(xs[idx], idx % 3, 8, 4, 8), 1'b0); idx++; end
      if (obs_got) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: unexpected output %0d", obs_data);
        end else begin
          e = exp_q.pop_front(); void'(last_q.pop_front()); void'(cyc_q.pop_front());
          if (obs_data !== e) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", outs, obs_data, e); end
          $display("backpressure[%0d]: y=%0d expected %0d", outs, obs_data, e);
        end
        outs++;
      end
    end
    checks += 2;
    if (outs !== 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", outs); end
    if (stalls < 1) begin errors++; $display("FAIL bp_stall: got %0d stall cycles expected >0", stalls); end
  endtask

  task automatic test_last_bubbles();
    int xs[6]   = '{8'h11, 8'hC3, 8'h06, 8'hF4, 8'h1A, 8'h9E};
    int gaps[6] = '{0, 1, 2, 1, 2, 1};
    int idx = 0, outs = 0, gap = 0, e, ec;
    bit v, el;
    for (int t = 0; t < 60 && (idx < 6 || exp_q.size() > 0); t++) begin
      v = (idx < 6) && (gap == 0);
      step(0, v, (idx < 6) ? xs[idx] : 0, 1, (idx == 2 || idx == 5), 1'b1);
      if (obs_took) begin
        push(model(xs[idx], 1, 8, 4, 8), (idx == 2 || idx == 5));
        idx++;
        if (idx < 6) gap = gaps[idx];
      end else if (gap > 0) begin
        gap--;
      end
      if (obs_got) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL last_extra: unexpected output %0d", obs_data);
        end else begin
          e = exp_q.pop_front(); el = last_q.pop_front(); ec = cyc_q.pop_front();
          checks += 2;
          if (obs_data !== e) begin errors++; $display("FAIL last_data[%0d]: got %0d expected %0d", outs, obs_data, e); end
          if (obs_last !== el) begin errors++; $display("FAIL last_flag[%0d]: got %b expected %b", outs, obs_last, el); end
          if (obs_cycle - ec !== 3) begin errors++; $display("FAIL last_latency[%0d]: got %0d expected 3", outs, obs_cycle - ec); end
          $display("last[%0d]: y=%0d last=%b", outs, obs_data, obs_last);
        end
        outs++;
      end
    end
    checks++;
    if (outs !== 6) begin errors++; $display("FAIL last_count: got %0d expected 6", outs); end
  endtask

  task automatic test_reset_midstream();
    int took_n = 0, seen = 0;
    for (int t = 0; t < 3; t++) begin
      step(0, 1'b1, 8'h20, 0, 1'b1, 1'b0);
      if (obs_took) took_n++;
    end
    step(0, 1'b0, 0, 0, 1'b0, 1'b0);
    checks += 4;
    if (took_n !== 3) begin errors++; $display("FAIL rst_mid_took: got %0d expected 3", took_n); end
    if (obs_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_valid: got %b expected 1", obs_valid); end
    if (obs_data !== 224) begin errors++; $display("FAIL rst_mid_pre_data: got %0d expected 224", obs_data); end
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_pre_ready: got %b expected 0", obs_ready); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks += 4;
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus_a.out_valid); end
    if (bus_a.out_data !== 8'd0)  begin errors++; $display("FAIL rst_mid_data: got %0d expected 0", bus_a.out_data); end
    if (bus_a.out_last !== 1'b0)  begin errors++; $display("FAIL rst_mid_last: got %b expected 0", bus_a.out_last); end
    if (bus_a.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", bus_a.in_ready); end
    for (int t = 0; t < 8; t++) begin
      step(0, 1'b0, 0, 0, 1'b0, 1'b1);
      if (obs_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_flush: got %0d outputs expected 0", seen); end
    $display("reset_midstream: flushed, %0d outputs after reset", seen);
  endtask

  task automatic test_sweep();
    int xs[5] = '{12'h000, 12'h100, 12'hF00, 12'h500, 12'h800};
    int ys[5] = '{512, 768, 256, 1023, 0};
    int idx = 0, outs = 0, e;
    for (int t = 0; t < 40 && (idx < 5 || exp_q.size() > 0); t++) begin
      step(1, idx < 5, (idx < 5) ? xs[idx] : 0, 0, 1'b0, 1'b1);
      if (obs_took) begin push(ys[idx], 1'b0); idx++; end
      if (obs_got) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sweep_extra: unexpected output %0d", obs_data);
        end else begin
          e = exp_q.pop_front(); void'(last_q.pop_front()); void'(cyc_q.pop_front());
          if (obs_data !== e) begin errors++; $display("FAIL sweep_data[%0d]: got %0d expected %0d", outs, obs_data, e); end
          $display("sweep[%0d]: y=%0d expected %0d", outs, obs_data, e);
        end
        outs++;
      end
    end
    checks++;
    if (outs !== 5) begin errors++; $display("FAIL sweep_count: got %0d expected 5", outs); end
  endtask

  task automatic test_random(input int which);
    int iw, ifr, ow, d, m, n = 0, outs = 0, e;
    bit l, v, el;
    iw  = (which != 0) ? 12 : 8;
    ifr = (which != 0) ? 8 : 4;
    ow  = (which != 0) ? 10 : 8;
    d = int'($urandom_range(0, (1 << iw) - 1)); m = int'($urandom_range(0, 3));
    l = 1'($urandom_range(0, 1)); v = 1'b1;
    for (int t = 0; t < 3000 && (n < 150 || exp_q.size() > 0); t++) begin
      step(which, v && (n < 150), d, m, l, ($urandom_range(0, 3) != 0));
      if (obs_took) begin
        push(model(d, m, iw, ifr, ow), l);
        n++;
      end
      if (obs_took || !v) begin
        d = int'($urandom_range(0, (1 << iw) - 1)); m = int'($urandom_range(0, 3));
        l = 1'($urandom_range(0, 1)); v = ($urandom_range(0, 3) != 0);
      end
      if (obs_got) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand%0d_extra: unexpected output %0d", which, obs_data);
        end else begin
          e = exp_q.pop_front(); el = last_q.pop_front(); void'(cyc_q.pop_front());
          checks++;
          if (obs_data !== e) begin errors++; $display("FAIL rand%0d_data[%0d]: got %0d expected %0d", which, outs, obs_data, e); end
          if (obs_last !== el) begin errors++; $display("FAIL rand%0d_last[%0d]: got %b expected %b", which, outs, obs_last, el); end
          $display("random%0d[%0d]: y=%0d expected %0d", which, outs, obs_data, e);
        end
        outs++;
      end
    end
    checks++;
    if (outs !== 150) begin errors++; $display("FAIL rand%0d_count: got %0d expected 150", which, outs); end
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_mode = '0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_mode = '0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b1;
    test_reset();
    test_sigmoid();
    test_modes();
    test_backpressure();
    test_last_bubbles();
    test_reset_midstream();
    test_sweep();
    test_random(0);
    test_random(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
